// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed multiply (radix-2 Booth) and divide
// (restoring, on magnitudes) writing the HI/LO register pair.
// Optional macro MULTDIV_UNSIGNED_EN adds an Unsigned input selecting
// MULTU/DIVU behaviour; without it every operation is signed.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             Unsigned,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             DivZero
);
    typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH:0]     p_hi_reg;   // Booth accumulator / division remainder
    logic [WIDTH-1:0]   p_lo_reg;   // multiplier bits / dividend-quotient shifter
    logic [WIDTH-1:0]   m_reg;      // multiplicand / divisor magnitude
    logic               q1_reg, neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               busy_reg, done_reg, div_zero_reg;

    logic               uns_reg;    // operation is unsigned (always 0 without the option)
    logic               uns_in;
`ifdef MULTDIV_UNSIGNED_EN
    assign uns_in = Unsigned;
`else
    assign uns_in = 1'b0;
`endif

    logic               last_iter;
    logic [WIDTH:0]     m_ext, mult_sum, mult_hi_next;
    logic [WIDTH-1:0]   mult_lo_next;
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_next, div_quo_next, quo_final, rem_final;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));
    assign abs_a     = (!uns_in && A[WIDTH-1]) ? -A : A;
    assign abs_b     = (!uns_in && B[WIDTH-1]) ? -B : B;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; divide by zero skips the iterations entirely
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (MultCtrl)     state_next = MULT_RUN;
                else if (DivCtrl) state_next = (B == '0) ? DONE : DIV_RUN;
            end
            MULT_RUN: if (last_iter) state_next = DONE;
            DIV_RUN:  if (last_iter) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // One multiply step: Booth add/sub (or plain shift-add when unsigned) then shift
    always_comb begin
        m_ext    = uns_reg ? {1'b0, m_reg} : {m_reg[WIDTH-1], m_reg};
        mult_sum = p_hi_reg;
        if (uns_reg) begin
            if (p_lo_reg[0]) mult_sum = p_hi_reg + m_ext;
            mult_hi_next = {1'b0, mult_sum[WIDTH:1]};
        end else begin
            case ({p_lo_reg[0], q1_reg})
                2'b01:   mult_sum = p_hi_reg + m_ext;
                2'b10:   mult_sum = p_hi_reg - m_ext;
                default: mult_sum = p_hi_reg;
            endcase
            mult_hi_next = {mult_sum[WIDTH], mult_sum[WIDTH:1]};
        end
        mult_lo_next = {mult_sum[0], p_lo_reg[WIDTH-1:1]};
    end

    // One restoring-division step plus final sign correction
    always_comb begin
        div_shifted  = {p_hi_reg[WIDTH-1:0], p_lo_reg[WIDTH-1]};
        div_diff     = {1'b0, div_shifted} - {2'b00, m_reg};
        div_ge       = ~div_diff[WIDTH+1];
        div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
        div_quo_next = {p_lo_reg[WIDTH-2:0], div_ge};
        quo_final    = neg_q_reg ? -div_quo_next : div_quo_next;
        rem_final    = neg_r_reg ? -div_rem_next : div_rem_next;
    end

    // Datapath: operand capture, iteration, and HI/LO write on DONE entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg      <= '0;
            p_hi_reg     <= '0;
            p_lo_reg     <= '0;
            m_reg        <= '0;
            q1_reg       <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            uns_reg      <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (MultCtrl) begin
                        m_reg    <= A;
                        p_lo_reg <= B;
                        p_hi_reg <= '0;
                        q1_reg   <= 1'b0;
                        uns_reg  <= uns_in;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                    end else if (DivCtrl) begin
                        if (B == '0) begin
                            done_reg     <= 1'b1;
                            div_zero_reg <= 1'b1;
                        end else begin
                            m_reg     <= abs_b;
                            p_lo_reg  <= abs_a;
                            p_hi_reg  <= '0;
                            neg_q_reg <= !uns_in && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r_reg <= !uns_in && A[WIDTH-1];
                            uns_reg   <= uns_in;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                MULT_RUN: begin
                    p_hi_reg <= mult_hi_next;
                    p_lo_reg <= mult_lo_next;
                    q1_reg   <= p_lo_reg[0];
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        hi_reg   <= mult_hi_next[WIDTH-1:0];
                        lo_reg   <= mult_lo_next;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end
                end
                DIV_RUN: begin
                    p_hi_reg <= {1'b0, div_rem_next};
                    p_lo_reg <= div_quo_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (last_iter) begin
                        hi_reg   <= rem_final;
                        lo_reg   <= quo_final;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI      = hi_reg;
    assign LO      = lo_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign DivZero = div_zero_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard testbench for mult_div_unit: stimulus pushes expected
// {HI, LO, DivZero}; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    logic        clk;
    logic        reset;
    logic        MultCtrl, DivCtrl;
    logic [31:0] A, B;
    logic [31:0] HI, LO;
    logic        busy, done, DivZero;
`ifdef MULTDIV_UNSIGNED_EN
    logic        Unsigned;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] sb_q[$];

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl),
`ifdef MULTDIV_UNSIGNED_EN
        .Unsigned(Unsigned),
`endif
        .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done), .DivZero(DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset === 1'b1 && DivZero === 1'b1 && done !== 1'b1)
            check("DivZero without done", 64'(done), 64'd1);
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected done", 64'd1, 64'd0);
            end else begin
                logic [64:0] e;
                e = sb_q.pop_front();
                check("result HI", 64'(HI), 64'(e[64:33]));
                check("result LO", 64'(LO), 64'(e[32:1]));
                check("result DivZero", 64'(DivZero), 64'(e[0]));
            end
        end
    end

    // One operation: start, scramble inputs, measure latency and busy window
    task automatic run_op(input logic mul, input logic dv, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input int lat, input string tag);
        int n;
        int busy_cnt;
        @(negedge clk);
        MultCtrl = mul; DivCtrl = dv; A = a; B = b;
        sb_q.push_back({eh, el, edz});
        @(negedge clk);
        MultCtrl = 1'b0; DivCtrl = 1'b0; A = 32'hDEADBEEF; B = 32'h0;
        n = 1; busy_cnt = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat - 1));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;
        reset = 1'b0; MultCtrl = 1'b0; DivCtrl = 1'b0; A = '0; B = '0;
`ifdef MULTDIV_UNSIGNED_EN
        Unsigned = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset state", {HI, LO}, 64'd0);
        check("reset flags", {61'd0, busy, done, DivZero}, 64'd0);
        reset = 1'b1;

        run_op(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33, "mul 7*-3");
        run_op(1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0, 33, "mul max*max");
        run_op(1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 33, "mul min*min");
        run_op(0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, "div -7/2");
        run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 33, "div min/-1");
        run_op(0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 33, "div 100/7");
        run_op(0, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, 33, "div 7/-2");
        // -0x2468ACF0 * -2^31 = 0x12345678 << 32
        run_op(1, 0, 32'hDB975310, 32'h80000000, 32'h12345678, 32'h00000000, 0, 33, "mul preload");
        run_op(0, 1, 32'd55, 32'd0, 32'h12345678, 32'h00000000, 1, 1, "div by zero");

        // Both starts high: multiply wins; later starts mid-run and in DONE are ignored
        @(negedge clk);
        MultCtrl = 1'b1; DivCtrl = 1'b1; A = 32'd6; B = 32'd4;
        sb_q.push_back({32'd0, 32'd24, 1'b0});
        @(negedge clk);
        MultCtrl = 1'b0; DivCtrl = 1'b0; A = 32'd11; B = 32'd0;
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 10) begin MultCtrl = 1'b1; DivCtrl = 1'b1; A = 32'd9; end
            if (n == 11) begin MultCtrl = 1'b0; DivCtrl = 1'b0; end
        end
        check("mul+div latency", 64'(n), 64'd33);
        MultCtrl = 1'b1; A = 32'd1; B = 32'd1;
        @(negedge clk);
        MultCtrl = 1'b0;
        extra = 0;
        repeat (40) begin
            if (done === 1'b1) extra++;
            @(negedge clk);
        end
        check("ignored starts no done", 64'(extra), 64'd0);
        check("ignored starts HI/LO", {HI, LO}, {32'd0, 32'd24});

        // Reset mid-operation aborts without writing a result
        @(negedge clk);
        MultCtrl = 1'b1; A = 32'd5; B = 32'd5;
        @(negedge clk);
        MultCtrl = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort HI/LO", {HI, LO}, 64'd0);
        check("abort flags", {61'd0, busy, done, DivZero}, 64'd0);
        reset = 1'b1;
        run_op(1, 0, 32'd3, 32'd3, 32'd0, 32'd9, 0, 33, "mul 3*3 after reset");

        repeat (5) @(negedge clk);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle signed multiply/divide datapath driven directly by the control unit's MultCtrl/DivCtrl start pulses.
- Operands come from register-file outputs A (rs) and B (rt).
- Results go to the HI/LO registers, which the control unit's MFHI/MFLO states read back.
- Provides busy/done so the control FSM can wait, and a DivZero flag that the exception logic consumes.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- MultCtrl  input  1  start signed multiply (A*B), sampled in IDLE
- DivCtrl  input  1  start signed divide (A/B), sampled in IDLE
- A  input  WIDTH  operand rs (multiplicand / dividend)
- B  input  WIDTH  operand rt (multiplier / divisor)
- HI  output  WIDTH  mult: upper product word; div: remainder
- LO  output  WIDTH  mult: lower product word; div: quotient
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: HI/LO updated or operation aborted
- DivZero  output  1  one-cycle pulse, coincident with done, on divide by zero

Behaviour:
- States:
  - IDLE: the only state in which starts are accepted.
  - MULT_RUN.
  - DIV_RUN.
  - DONE: lasts exactly 1 cycle, then returns to IDLE.
- Reset (reset==0 at an edge), from any state including mid-operation:
  - State goes to IDLE.
  - HI=0, LO=0, busy=0, done=0, DivZero=0.
  - Counter and internal operand registers are cleared.
  - No partial result is ever written.
- Start: in IDLE, at edge k, with MultCtrl or DivCtrl high:
  - A and B are captured into internal registers. A/B may change afterwards without effect.
  - Counter is set to 0 and busy=1 from after edge k.
  - MultCtrl and DivCtrl both high: multiply wins; DivCtrl is ignored.
  - A start while busy or in DONE is ignored (not queued).
- Multiply:
  - Radix-2 Booth over {P_hi, P_lo, q-1}, one iteration per edge.
  - Edges k+1 .. k+WIDTH perform iterations 0..WIDTH-1.
  - At edge k+WIDTH, the state goes to DONE and {HI,LO} = full 2*WIDTH signed product.
- Divide:
  - Restoring division on the magnitudes |A| and |B|, one quotient bit per edge, same timing as multiply.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A) (truncation toward zero).
  - LO = quotient, HI = remainder.
  - A = 0x80000000, B = 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no flag).
- Divide by zero: B==0 at capture edge k:
  - No iterations run; the state goes directly to DONE at edge k.
  - DivZero=1 and done=1 in that cycle.
  - HI and LO keep their previous values.
- DONE state:
  - done=1, busy=0.
  - HI/LO already hold the new value.
  - A new start in the DONE cycle is ignored.
- Latency:
  - Normal operation: done high in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after the start is seen.
  - Divide by zero: done in the cycle right after edge k.
- HI/LO change only at the DONE entry edge or on reset; they hold indefinitely between operations.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro MULTDIV_UNSIGNED_EN.
- Defined:
  - Adds input port Unsigned (1 bit), sampled together with the start.
  - Unsigned=1: multiply is unsigned (shift-add, zero-extended).
  - Unsigned=1: divide uses the raw operands without sign correction, giving MULTU/DIVU semantics. Timing and divide-by-zero rules are unchanged.
- Not defined: the port is absent and all operations are signed.

Test Plan:
- Mult, A=7, B=0xFFFFFFFD (−3) -> done after 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB, DivZero=0, busy high for cycles 1..32.
- Mult, A=B=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001. Then mult A=B=0x80000000 -> HI=0x40000000, LO=0.
- Div, A=0xFFFFFFF9 (−7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x12345678 via a mult, then div with B=0 -> done and DivZero pulse exactly one cycle after start, HI/LO unchanged, busy never high.
- Simultaneous MultCtrl=DivCtrl=1 with A=6, B=4 -> HI=0, LO=24. Start pulses issued mid-run and in the DONE cycle are ignored (result unchanged, no second done).
- Start mult 5*5, drive reset=0 at cycle 10 -> next cycle state IDLE, HI=LO=0, busy=done=0. A fresh mult 3*3 afterwards gives LO=9 after 33 cycles.
